// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: the master raises start with A/B/Cin valid; the adder takes them
// on any rising edge where it is not busy (IDLE or the DONE cycle). busy is
// high while bits are being processed, and done pulses for one cycle when
// Sum/Cout are updated. Starts seen while busy are dropped. There is no
// backpressure on the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start. The result appears WIDTH clocks
// later, together with a one-cycle done pulse, and is held until the next
// completion or reset.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus,
    output logic [1:0]    state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout;
    logic             busy;
    logic             done;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sh_s_next;

    // Full-adder cell on the current LSBs; the new sum bit enters shS at the MSB
    always_comb begin
        bit_s     = sh_a[0] ^ sh_b[0] ^ carry;
        bit_c     = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        sh_s_next = WIDTH'({bit_s, sh_s} >> 1);
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.Sum  = sum;
    assign bus.Cout = cout;

    // Control FSM and datapath; reset wins over start and any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            sum   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new start exactly like IDLE for back-to-back use
                    done <= 1'b0;
                    if (bus.start) begin
                        sh_a  <= bus.A;
                        sh_b  <= bus.B;
                        carry <= bus.Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= bit_c;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= sh_s_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Result is published only once all bits are in
                        sum   <= sh_s_next;
                        cout  <= bit_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH = 8, 1 and 32. A cycle-level model built
// from the arithmetic rules is compared every cycle; directed results are
// also pinned with hand-computed literals.
module tb_serial_adder;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    function automatic int width_of(int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [32:0] ref_add(int k, logic [31:0] a, logic [31:0] b, logic c);
        logic [31:0] m;
        m = mask_of(width_of(k));
        return {1'b0, a & m} + {1'b0, b & m} + 33'(c);
    endfunction

    // ---------------- DUT instances ----------------
    logic        start_v [NDUT];
    logic [31:0] a_v     [NDUT];
    logic [31:0] b_v     [NDUT];
    logic        cin_v   [NDUT];
    logic        busy_v  [NDUT];
    logic        done_v  [NDUT];
    logic        cout_v  [NDUT];
    logic [31:0] sum_v   [NDUT];
    logic [1:0]  state_v [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int W = (k == 0) ? 8 : (k == 1) ? 1 : 32;
        serial_adder_if #(.WIDTH(W)) bus ();
        assign bus.start = start_v[k];
        assign bus.A     = a_v[k][W-1:0];
        assign bus.B     = b_v[k][W-1:0];
        assign bus.Cin   = cin_v[k];
        assign busy_v[k] = bus.busy;
        assign done_v[k] = bus.done;
        assign cout_v[k] = bus.Cout;
        assign sum_v[k]  = 32'(bus.Sum);
        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .bus   (bus),
            .state (state_v[k])
        );
    end

    // ---------------- behavioural model ----------------
    logic        m_busy [NDUT];
    logic        m_done [NDUT];
    logic        m_cout [NDUT];
    logic [31:0] m_sum  [NDUT];
    logic [32:0] m_exp  [NDUT];
    int          m_left [NDUT];

    // An accepted operation finishes WIDTH edges later; its result then holds
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_cout[k] <= 1'b0;
                m_sum[k]  <= '0;
                m_exp[k]  <= '0;
                m_left[k] <= 0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_busy[k]) begin
                    if (m_left[k] == 1) begin
                        m_busy[k] <= 1'b0;
                        m_done[k] <= 1'b1;
                        m_sum[k]  <= m_exp[k][31:0] & mask_of(width_of(k));
                        m_cout[k] <= m_exp[k][width_of(k)];
                    end else begin
                        m_left[k] <= m_left[k] - 1;
                    end
                end else if (start_v[k]) begin
                    m_busy[k] <= 1'b1;
                    m_left[k] <= width_of(k);
                    m_exp[k]  <= ref_add(k, a_v[k], b_v[k], cin_v[k]);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {dut index, expected {Cout,Sum} as a number}
    logic [34:0] exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;
    logic wd_timeout = 1'b0;
    logic wd_seen = 1'b0;
    logic fin_req = 1'b0;
    logic fin_ack = 1'b0;

    task automatic chk(string name, int k, logic [32:0] act, logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s w=%0d t=%0t actual=%h required=%h", name, width_of(k), $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                chk("busy", k, 33'(busy_v[k]), 33'(m_busy[k]));
                chk("done", k, 33'(done_v[k]), 33'(m_done[k]));
                chk("sum",  k, 33'(sum_v[k]),  33'(m_sum[k]));
                chk("cout", k, 33'(cout_v[k]), 33'(m_cout[k]));
                chk("busy_and_done", k, 33'(busy_v[k] & done_v[k]), 33'd0);
                if (done_v[k] === 1'b1 && exp_q.size() > 0 && int'(exp_q[0][34:33]) == k) begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    chk("literal", k, (33'(cout_v[k]) << width_of(k)) | 33'(sum_v[k]), e[32:0]);
                end
            end
        end
        if (wd_timeout && !wd_seen) begin
            wd_seen = 1'b1;
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout t=%0t actual=no done required=done", $time);
        end
        if (fin_req && !fin_ack) begin
            chk("pending_literals", 0, 33'(exp_q.size()), 33'd0);
            fin_ack = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns one negedge later with start dropped
    task automatic start_op(int k, logic [31:0] a, logic [31:0] b, logic c,
                            logic push, logic [32:0] lit);
        start_v[k] = 1'b1;
        a_v[k]     = a;
        b_v[k]     = b;
        cin_v[k]   = c;
        if (push) exp_q.push_back({2'(k), lit});
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k]     = $urandom;
        b_v[k]     = $urandom;
        cin_v[k]   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(int k);
        int n;
        n = 0;
        while (done_v[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) wd_timeout = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            start_v[k] = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
            cin_v[k]   = 1'b0;
        end
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: 0F + 01
        start_op(0, 32'h0F, 32'h01, 1'b0, 1'b1, 33'h010);
        wait_done(0);
        repeat (3) @(negedge clk);

        // 2: carry out of the top bit
        start_op(0, 32'hFF, 32'h01, 1'b0, 1'b1, 33'h100);
        wait_done(0);
        @(negedge clk);
        start_op(0, 32'hFF, 32'hFF, 1'b1, 1'b1, 33'h1FF);
        wait_done(0);
        @(negedge clk);

        // 3: start during RUN is ignored
        start_op(0, 32'h55, 32'hAA, 1'b0, 1'b1, 33'h0FF);
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 32'h01;
        b_v[0]     = 32'h01;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        repeat (2) @(negedge clk);

        // 4: reset in the middle of an operation, then a clean one
        start_op(0, 32'h80, 32'h80, 1'b0, 1'b0, 33'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        start_op(0, 32'h80, 32'h80, 1'b0, 1'b1, 33'h100);
        wait_done(0);
        repeat (2) @(negedge clk);

        // 5: start held high, restart accepted in the DONE cycle
        start_v[0] = 1'b1;
        a_v[0]     = 32'h10;
        b_v[0]     = 32'h20;
        cin_v[0]   = 1'b0;
        exp_q.push_back({2'd0, 33'h030});
        @(negedge clk);
        a_v[0]     = 32'h7F;
        b_v[0]     = 32'h01;
        cin_v[0]   = 1'b1;
        exp_q.push_back({2'd0, 33'h081});
        wait_done(0);
        @(negedge clk);
        start_v[0] = 1'b0;
        a_v[0]     = 32'h33;
        @(negedge clk);
        wait_done(0);
        repeat (3) @(negedge clk);

        // 6a: WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            start_op(1, 32'(v[2]), 32'(v[1]), v[0], 1'b1,
                     33'(v[2]) + 33'(v[1]) + 33'(v[0]));
            wait_done(1);
            @(negedge clk);
        end

        // 6b: WIDTH=32 pins, then random vectors against the model
        start_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 33'h1_0000_0000);
        wait_done(2);
        @(negedge clk);
        start_op(2, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 33'h0_2345_678A);
        wait_done(2);
        for (int i = 0; i < 1000; i++) begin
            start_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 33'h0);
            wait_done(2);
        end
        repeat (3) @(negedge clk);

        fin_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
